// File: rtl/lsu_ctrl.sv
// lsu_ctrl: RV32I load/store unit controller between the execute stage and a
// byte-lane data memory. Accepts one request at a time, issues a single
// memory access, extends load data and returns a one-cycle response.
// Optional build macro LSU_MISALIGN_TRAP_EN: when defined, misaligned
// half/word accesses are rejected with an error instead of being force-aligned.
module lsu_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_error,
    output logic        data_enable,
    output logic        data_read,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] ram_address,
    output logic [31:0] ram_store,
    input  logic [31:0] ram_fetch,
    input  logic        misaligned
);

    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

    state_t      state_q, state_d;
    logic        store_q, store_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [1:0]  lane_q, lane_d;
    logic        data_enable_q, data_enable_d;
    logic        data_read_q, data_read_d;
    logic [3:0]  mem_wstrb_q, mem_wstrb_d;
    logic [31:0] ram_address_q, ram_address_d;
    logic [31:0] ram_store_q, ram_store_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_error_q, rsp_error_d;
    logic [31:0] addr_al;

    // Stores accept SB/SH/SW only; loads also accept LBU/LHU.
    function automatic logic funct3_legal(input logic st, input logic [2:0] f3);
        logic ok;
        if (st) begin
            ok = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010);
        end else begin
            ok = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
                 (f3 == 3'b100) || (f3 == 3'b101);
        end
        return ok;
    endfunction

    // Half needs addr[0]=0, word needs addr[1:0]=00; f3[1:0] encodes the size.
    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] a);
        logic mis;
        case (f3[1:0])
            2'b01:   mis = a[0];
            2'b10:   mis = (a != 2'b00);
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

    // Clear the offending low address bits for the access size.
    function automatic logic [31:0] align_addr(input logic [2:0] f3, input logic [31:0] a);
        logic [31:0] r;
        r = a;
        case (f3[1:0])
            2'b01:   r[0]   = 1'b0;
            2'b10:   r[1:0] = 2'b00;
            default: r      = a;
        endcase
        return r;
    endfunction

    // Byte-lane write strobe; data itself stays right-justified.
    function automatic logic [3:0] store_strobe(input logic [2:0] f3, input logic [1:0] a);
        logic [3:0] s;
        case (f3)
            3'b000:  s = 4'b0001 << a;
            3'b001:  s = a[1] ? 4'b1100 : 4'b0011;
            3'b010:  s = 4'b1111;
            default: s = 4'b0000;
        endcase
        return s;
    endfunction

    // Pick the addressed lane out of the fetched word and extend it.
    function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] a,
                                                input logic [31:0] fetch);
        logic [31:0] sh;
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        sh = fetch >> {a, 3'b000};
        b  = sh[7:0];
        h  = a[1] ? fetch[31:16] : fetch[15:0];
        case (f3)
            3'b000:  r = {{24{b[7]}}, b};
            3'b001:  r = {{16{h[15]}}, h};
            3'b100:  r = {24'b0, b};
            3'b101:  r = {16'b0, h};
            default: r = fetch;
        endcase
        return r;
    endfunction

    assign addr_al = align_addr(req_funct3, req_addr);

    // Next-state, request latching and registered port values.
    always_comb begin
        state_d       = state_q;
        store_d       = store_q;
        funct3_d      = funct3_q;
        lane_d        = lane_q;
        data_enable_d = 1'b0;
        data_read_d   = 1'b0;
        mem_wstrb_d   = 4'b0000;
        ram_address_d = 32'b0;
        ram_store_d   = 32'b0;
        rsp_valid_d   = 1'b0;
        rsp_rdata_d   = 32'b0;
        rsp_error_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    store_d  = req_store;
                    funct3_d = req_funct3;
                    lane_d   = addr_al[1:0];
                    if (!funct3_legal(req_store, req_funct3)) begin
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        rsp_error_d = 1'b1;
                    end
`ifdef LSU_MISALIGN_TRAP_EN
                    else if (is_misaligned(req_funct3, req_addr[1:0])) begin
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        rsp_error_d = 1'b1;
                    end
`endif
                    else begin
                        state_d       = ACCESS;
                        data_enable_d = 1'b1;
                        data_read_d   = !req_store;
                        mem_wstrb_d   = req_store ? store_strobe(req_funct3, addr_al[1:0]) : 4'b0000;
                        ram_address_d = {addr_al[31:2], 2'b00};
                        ram_store_d   = req_store ? req_wdata : 32'b0;
                    end
                end
            end
            ACCESS: begin
                if (store_q) begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                end else begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                state_d     = RESP;
                rsp_valid_d = 1'b1;
                rsp_error_d = misaligned;
                rsp_rdata_d = misaligned ? 32'b0 : load_extend(funct3_q, lane_q, ram_fetch);
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset drops any in-flight access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            store_q       <= 1'b0;
            funct3_q      <= 3'b000;
            lane_q        <= 2'b00;
            data_enable_q <= 1'b0;
            data_read_q   <= 1'b0;
            mem_wstrb_q   <= 4'b0000;
            ram_address_q <= 32'b0;
            ram_store_q   <= 32'b0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= 32'b0;
            rsp_error_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            store_q       <= store_d;
            funct3_q      <= funct3_d;
            lane_q        <= lane_d;
            data_enable_q <= data_enable_d;
            data_read_q   <= data_read_d;
            mem_wstrb_q   <= mem_wstrb_d;
            ram_address_q <= ram_address_d;
            ram_store_q   <= ram_store_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_error_q   <= rsp_error_d;
        end
    end

    assign req_ready   = (state_q == IDLE);
    assign data_enable = data_enable_q;
    assign data_read   = data_read_q;
    assign mem_wstrb   = mem_wstrb_q;
    assign ram_address = ram_address_q;
    assign ram_store   = ram_store_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_error   = rsp_error_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Testbench for lsu_ctrl: directed requests against a small byte-lane memory
// model, with access and response scoreboards checked by monitors.
module tb_lsu_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_error;
    logic [31:0] rsp_rdata;
    logic        data_enable, data_read;
    logic [3:0]  mem_wstrb;
    logic [31:0] ram_address, ram_store, ram_fetch;
    logic        misaligned;
    logic        force_mis;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    typedef struct {
        logic [3:0]  ws;
        logic [31:0] ra;
        logic [31:0] wd;
        logic        rd;
        int          due;
    } acc_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          due;
    } rsp_t;

    acc_t acc_q[$];
    rsp_t rsp_q[$];

    logic [31:0] mem [0:63];

    lsu_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
        .data_enable(data_enable), .data_read(data_read), .mem_wstrb(mem_wstrb),
        .ram_address(ram_address), .ram_store(ram_store), .ram_fetch(ram_fetch),
        .misaligned(misaligned)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Registered byte-lane memory: read data and fault flag appear the cycle after access.
    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        ram_fetch  = 32'h0;
        misaligned = 1'b0;
    end

    always @(posedge clk) begin
        if (data_enable) begin
            if (data_read) begin
                ram_fetch  <= mem[ram_address[7:2]];
                misaligned <= force_mis;
            end else begin
                case (mem_wstrb)
                    4'b1111: mem[ram_address[7:2]]        <= ram_store;
                    4'b0011: mem[ram_address[7:2]][15:0]  <= ram_store[15:0];
                    4'b1100: mem[ram_address[7:2]][31:16] <= ram_store[15:0];
                    4'b0001: mem[ram_address[7:2]][7:0]   <= ram_store[7:0];
                    4'b0010: mem[ram_address[7:2]][15:8]  <= ram_store[7:0];
                    4'b0100: mem[ram_address[7:2]][23:16] <= ram_store[7:0];
                    4'b1000: mem[ram_address[7:2]][31:24] <= ram_store[7:0];
                    default: ;
                endcase
            end
        end
    end

    // Access monitor: every data_enable cycle must match the next expected access.
    always @(negedge clk) begin
        if (rst_n && data_enable) begin
            if (acc_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_access: addr %h wstrb %b, expected none", ram_address, mem_wstrb);
            end else begin
                acc_t e;
                e = acc_q.pop_front();
                check("acc_cycle", cyc, e.due);
                check("acc_read", {31'b0, data_read}, {31'b0, e.rd});
                check("acc_wstrb", {28'b0, mem_wstrb}, {28'b0, e.ws});
                check("acc_addr", ram_address, e.ra);
                if (!e.rd) check("acc_store", ram_store, e.wd);
            end
        end
    end

    // Response monitor: every rsp_valid pulse must match the next expected response.
    always @(negedge clk) begin
        if (rst_n && rsp_valid) begin
            if (rsp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_rsp: rdata %h err %b, expected none", rsp_rdata, rsp_error);
            end else begin
                rsp_t e;
                e = rsp_q.pop_front();
                check("rsp_cycle", cyc, e.due);
                check("rsp_rdata", rsp_rdata, e.rdata);
                check("rsp_error", {31'b0, rsp_error}, {31'b0, e.err});
            end
        end
    end

    // Present a request, wait (bounded) for acceptance, and queue expectations.
    task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input logic acc, input logic [3:0] ws,
                         input logic [31:0] ra, input logic [31:0] rd, input logic er,
                         input int lat, input logic want_rsp, output int waited);
        acc_t ae;
        rsp_t re;
        @(negedge clk);
        req_valid  = 1'b1;
        req_store  = st;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        waited     = 0;
        while (!req_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!req_ready) begin
            n_chk++;
            n_fail++;
            $display("FAIL accept_timeout: req_ready stayed 0, expected 1");
        end else begin
            if (acc) begin
                ae.ws = ws; ae.ra = ra; ae.wd = wd; ae.rd = !st; ae.due = cyc + 1;
                acc_q.push_back(ae);
            end
            if (want_rsp) begin
                re.rdata = rd; re.err = er; re.due = cyc + lat;
                rsp_q.push_back(re);
            end
            @(posedge clk);
        end
    endtask

    task automatic store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                         input logic [3:0] ws, output int w);
        issue(1'b1, f3, a, wd, 1'b1, ws, {a[31:2], 2'b00}, 32'h0, 1'b0, 2, 1'b1, w);
    endtask

    task automatic load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd,
                        output int w);
        issue(1'b0, f3, a, 32'h0, 1'b1, 4'b0000, {a[31:2], 2'b00}, rd, 1'b0, 3, 1'b1, w);
    endtask

    task automatic reject(input logic st, input logic [2:0] f3, input logic [31:0] a, output int w);
        issue(st, f3, a, 32'h0, 1'b0, 4'b0000, 32'h0, 32'h0, 1'b1, 1, 1'b1, w);
    endtask

    task automatic drain();
        int n;
        @(negedge clk);
        req_valid = 1'b0;
        n = 0;
        while ((acc_q.size() != 0 || rsp_q.size() != 0) && n < 30) begin
            @(negedge clk);
            n++;
        end
        check("drain_acc", acc_q.size(), 0);
        check("drain_rsp", rsp_q.size(), 0);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_ready"}, {31'b0, req_ready}, 32'h1);
        check({tag, "_den"}, {31'b0, data_enable}, 32'h0);
        check({tag, "_dread"}, {31'b0, data_read}, 32'h0);
        check({tag, "_wstrb"}, {28'b0, mem_wstrb}, 32'h0);
        check({tag, "_raddr"}, ram_address, 32'h0);
        check({tag, "_rstore"}, ram_store, 32'h0);
        check({tag, "_rvalid"}, {31'b0, rsp_valid}, 32'h0);
        check({tag, "_rdata"}, rsp_rdata, 32'h0);
        check({tag, "_rerr"}, {31'b0, rsp_error}, 32'h0);
    endtask

    initial begin
        int w;
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_store  = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        force_mis  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);
        check_idle_outputs("post_reset");

        // Stores of each size, then loads that read back lanes with extension.
        store(3'b010, 32'h0000_0010, 32'hDEAD_BEEF, 4'b1111, w);
        store(3'b000, 32'h0000_0013, 32'h0000_00A5, 4'b1000, w);
        load(3'b000, 32'h0000_0013, 32'hFFFF_FFA5, w);
        load(3'b100, 32'h0000_0013, 32'h0000_00A5, w);
        store(3'b001, 32'h0000_0022, 32'h0000_8001, 4'b1100, w);
        load(3'b001, 32'h0000_0022, 32'hFFFF_8001, w);
        load(3'b101, 32'h0000_0022, 32'h0000_8001, w);
        store(3'b001, 32'h0000_0020, 32'h0000_7FFE, 4'b0011, w);
        load(3'b010, 32'h0000_0020, 32'h8001_7FFE, w);
        load(3'b010, 32'h0000_0010, 32'hA5AD_BEEF, w);
        load(3'b000, 32'h0000_0011, 32'hFFFF_FFBE, w);
        load(3'b100, 32'h0000_0012, 32'h0000_00AD, w);
        load(3'b001, 32'h0000_0010, 32'hFFFF_BEEF, w);
        store(3'b010, 32'h0000_0030, 32'h1234_5678, 4'b1111, w);
        drain();

        // Misaligned half/word: trapped or force-aligned depending on build.
`ifdef LSU_MISALIGN_TRAP_EN
        reject(1'b0, 3'b010, 32'h0000_0031, w);
        reject(1'b0, 3'b001, 32'h0000_0023, w);
        reject(1'b1, 3'b010, 32'h0000_0032, w);
`else
        load(3'b010, 32'h0000_0031, 32'h1234_5678, w);
        load(3'b001, 32'h0000_0023, 32'hFFFF_8001, w);
        store(3'b010, 32'h0000_0032, 32'hCAFE_F00D, 4'b1111, w);
        load(3'b010, 32'h0000_0030, 32'hCAFE_F00D, w);
`endif
        drain();

        // Illegal funct3 for loads and stores: error with no memory access.
        reject(1'b0, 3'b011, 32'h0000_0010, w);
        check("err_spacing", w, 0);
        reject(1'b0, 3'b110, 32'h0000_0010, w);
        check("err_ready_wait", w, 1);
        reject(1'b0, 3'b111, 32'h0000_0010, w);
        reject(1'b1, 3'b011, 32'h0000_0010, w);
        reject(1'b1, 3'b100, 32'h0000_0010, w);
        drain();

        // Memory-side fault flag reported on a load.
        force_mis = 1'b1;
        issue(1'b0, 3'b010, 32'h0000_0010, 32'h0, 1'b1, 4'b0000, 32'h0000_0010,
              32'h0, 1'b1, 3, 1'b1, w);
        drain();
        force_mis = 1'b0;

        // Reset while in WAIT: no response, everything back to idle at once.
        issue(1'b0, 3'b010, 32'h0000_0010, 32'h0, 1'b1, 4'b0000, 32'h0000_0010,
              32'h0, 1'b0, 3, 1'b0, w);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_idle_outputs("mid_reset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("mid_reset_no_rsp", rsp_q.size(), 0);
        check("mid_reset_ready", {31'b0, req_ready}, 32'h1);

        // Valid held high with alternating SW/LW: one access each, ready low while busy.
        store(3'b010, 32'h0000_0040, 32'h1111_1111, 4'b1111, w);
        load(3'b010, 32'h0000_0040, 32'h1111_1111, w);
        check("b2b_wait_after_sw", w, 2);
        store(3'b010, 32'h0000_0040, 32'h2222_2222, 4'b1111, w);
        check("b2b_wait_after_lw", w, 3);
        load(3'b010, 32'h0000_0040, 32'h2222_2222, w);
        check("b2b_wait_after_sw2", w, 2);
        store(3'b010, 32'h0000_0044, 32'h3333_3333, 4'b1111, w);
        check("b2b_wait_after_lw2", w, 3);
        load(3'b010, 32'h0000_0044, 32'h3333_3333, w);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/lsu_ctrl.md
# lsu_ctrl

Load/store unit controller sitting between the core's execute stage and the byte-lane data memory. It accepts one RV32I load or store request at a time and drives the memory port: `data_enable`, `data_read`, `mem_wstrb`, `ram_address` and `ram_store`. It then captures `ram_fetch`, sign- or zero-extends the addressed lane, and returns a single-cycle response. Alignment checking and funct3 validation are done here, before any memory access is issued.

## Interface
- No parameters.
- `clk` in 1 — clock.
- `rst_n` in 1 — reset; asynchronous, active-low.
- `req_valid` in 1 — request present.
- `req_ready` out 1 — high only in IDLE; a request is accepted on a `req_valid && req_ready` edge.
- `req_store` in 1 — 1 = store, 0 = load.
- `req_funct3` in 3 — RV32I encoding:
  - Loads: LB=000, LH=001, LW=010, LBU=100, LHU=101.
  - Stores: SB=000, SH=001, SW=010.
- `req_addr` in 32 — byte address.
- `req_wdata` in 32 — store data, right-justified.
- `rsp_valid` out 1 — one-cycle response pulse.
- `rsp_rdata` out 32 — extended load data; 0 for stores and errors.
- `rsp_error` out 1 — qualified by `rsp_valid`.
- `data_enable` out 1 — memory access strobe.
- `data_read` out 1 — 1 = read, 0 = write.
- `mem_wstrb` out 4 — byte-lane write strobe.
- `ram_address` out 32 — word-aligned address `{addr[31:2],2'b00}`.
- `ram_store` out 32 — store data, unshifted.
- `ram_fetch` in 32 — registered memory read data, valid the cycle after the access.
- `misaligned` in 1 — memory-side fault flag, sampled with `ram_fetch`.

## Operation
- **FSM states:** IDLE, ACCESS, WAIT, RESP.
  - IDLE → ACCESS on accept of a legal request.
  - IDLE → RESP on accept of an illegal request.
  - ACCESS → WAIT for a load; ACCESS → RESP for a store.
  - WAIT → RESP.
  - RESP → IDLE.
- On accept, latch store, funct3, addr and wdata. The request inputs are ignored outside IDLE.
- **Memory port outputs:** all are registered and are 0 except during ACCESS. `data_enable` is high for exactly one cycle per legal request.
- **Stores:**
  - Data is not lane-shifted: `ram_store` = wdata; the memory writes lane bytes from `ram_store[7:0]` / `[15:0]`.
  - SB: `mem_wstrb` = `4'b0001 << addr[1:0]`.
  - SH: 0011 if `addr[1]`=0, else 1100.
  - SW: 1111.
  - `data_read`=0.
- **Loads:**
  - During ACCESS, `data_read`=1 and `mem_wstrb`=0.
  - At the end of WAIT, select the lane from `ram_fetch`:
    - Byte: `ram_fetch[8k+7:8k]`, k=`addr[1:0]`.
    - Half: `[15:0]` or `[31:16]` by `addr[1]`.
  - Sign-extend for LB/LH; zero-extend for LBU/LHU. LW passes through.
  - `rsp_error` = sampled `misaligned`.
- **Illegal funct3:**
  - Loads: 011, 110, 111.
  - Stores: any value ≥ 011.
  - Result: no memory access, `rsp_error`=1, `rsp_rdata`=0, independent of configuration.
- **Misalignment:** a halfword with `addr[0]`=1, or a word with `addr[1:0]`≠00. Handling is set by Configuration.

## Timing
- Accept at edge t0.
- Store: ACCESS in cycle t0–t1; `rsp_valid` in cycle t1–t2. Latency is 2 cycles.
- Load: ACCESS, then WAIT (`ram_fetch` valid), then RESP. Latency is 3 cycles.
- Error path: RESP immediately after accept. Latency is 1 cycle.
- `rsp_valid` has no backpressure. `req_ready` returns high the cycle after RESP, so back-to-back requests are spaced 3 or 4 cycles.
- **Reset values:** every output is 0 except `req_ready`, which is 1 (IDLE). Reset mid-operation returns to IDLE, drops `data_enable` immediately and produces no response.

## Configuration
- **`LSU_MISALIGN_TRAP_EN` defined:** a misaligned access is not issued. It goes IDLE → RESP with `rsp_error`=1 and `rsp_rdata`=0.
- **Undefined:** the offending low address bits are cleared (half: `addr[0]`=0; word: `addr[1:0]`=00) and the access proceeds normally with `rsp_error`=0.

## Test plan
- SW addr 0x0000_0010, wdata 0xDEADBEEF -> one ACCESS cycle with `mem_wstrb`=1111, `ram_address`=0x10, `ram_store`=0xDEADBEEF; `rsp_valid` 2 cycles after accept.
- SB addr 0x13, wdata 0x0000_00A5 -> `mem_wstrb`=1000, `ram_store`=0x000000A5; follow with LB 0x13 -> `rsp_rdata`=0xFFFFFFA5; LBU -> 0x000000A5, 3 cycles after accept.
- SH addr 0x22, wdata 0x8001 -> `mem_wstrb`=1100; LH 0x22 -> 0xFFFF8001; LHU -> 0x00008001.
- LW addr 0x31:
  - With `LSU_MISALIGN_TRAP_EN` -> no `data_enable`, `rsp_error`=1 one cycle after accept.
  - Without -> access at 0x30, `rsp_error`=0.
- Load funct3=011 -> `rsp_error`=1, no memory access. `rst_n` asserted during WAIT -> no `rsp_valid`, `req_ready`=1, all port outputs 0.
- Hold `req_valid` continuously with alternating SW/LW -> exactly one access per request, `req_ready` low while busy, each read returns the last written value.
